// File: rtl/alu_exec_unit_pkg.sv
// Shared execute-unit definitions: widths and the opcode encoding used on the OpBus.
// The opcode values are common to RS, ROB and LSB, so changing them affects every consumer.
// No ports (package).
package alu_exec_unit_pkg;

   localparam int ALU_OP_W  = 6;
   localparam int ALU_ROB_W = 4;
   localparam int ALU_XLEN  = 32;

   // Code 0 is a bubble. Any code not listed here is treated as unknown.
   typedef enum logic [ALU_OP_W-1:0] {
      OP_NOP   = 6'd0,
      OP_LUI   = 6'd1,
      OP_AUIPC = 6'd2,
      OP_JAL   = 6'd3,
      OP_JALR  = 6'd4,
      OP_BEQ   = 6'd5,
      OP_BNE   = 6'd6,
      OP_BLT   = 6'd7,
      OP_BGE   = 6'd8,
      OP_BLTU  = 6'd9,
      OP_BGEU  = 6'd10,
      OP_ADDI  = 6'd11,
      OP_SLTI  = 6'd12,
      OP_SLTIU = 6'd13,
      OP_XORI  = 6'd14,
      OP_ORI   = 6'd15,
      OP_ANDI  = 6'd16,
      OP_SLLI  = 6'd17,
      OP_SRLI  = 6'd18,
      OP_SRAI  = 6'd19,
      OP_ADD   = 6'd20,
      OP_SUB   = 6'd21,
      OP_SLL   = 6'd22,
      OP_SLT   = 6'd23,
      OP_SLTU  = 6'd24,
      OP_XOR   = 6'd25,
      OP_SRL   = 6'd26,
      OP_SRA   = 6'd27,
      OP_OR    = 6'd28,
      OP_AND   = 6'd29
   } alu_op_e;

endpackage

// File: rtl/alu_exec_core.sv
// Combinational RV32I datapath: opcode and operands -> rd value, taken flag, redirect target.
// Ports: op_i, vj_i (rs1), vk_i (rs2), a_i (imm), pc_i -> value_o, jump_o, target_o.
// Latency 0, no state; unknown opcodes give value 0 and jump 0.
module alu_exec_core
   import alu_exec_unit_pkg::*;
#(
   parameter int OP_W = ALU_OP_W,
   parameter int XLEN = ALU_XLEN
) (
   input  logic [OP_W-1:0] op_i,
   input  logic [XLEN-1:0] vj_i,
   input  logic [XLEN-1:0] vk_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] pc_i,
   output logic [XLEN-1:0] value_o,
   output logic            jump_o,
   output logic [XLEN-1:0] target_o
);

   localparam int SHW = $clog2(XLEN);

   logic [SHW-1:0]  sh_imm;
   logic [SHW-1:0]  sh_reg;
   logic [XLEN-1:0] link;

   assign sh_imm = a_i[SHW-1:0];
   assign sh_reg = vk_i[SHW-1:0];
   assign link   = pc_i + XLEN'(4);

   // Zero-extend a compare result to a full data word.
   function automatic logic [XLEN-1:0] b2w(input logic b);
      logic [XLEN-1:0] w;
      w    = '0;
      w[0] = b;
      return w;
   endfunction

   always_comb begin
      value_o  = '0;
      jump_o   = 1'b0;
      // Branches and JAL share pc+imm; only JALR overrides it.
      target_o = pc_i + a_i;
      case (op_i)
         OP_LUI:   value_o = a_i;
         OP_AUIPC: value_o = pc_i + a_i;
         OP_JAL: begin
            value_o = link;
            jump_o  = 1'b1;
         end
         OP_JALR: begin
            value_o  = link;
            target_o = (vj_i + a_i) & {{(XLEN-1){1'b1}}, 1'b0};
            jump_o   = 1'b1;
         end
         OP_BEQ:   jump_o = (vj_i == vk_i);
         OP_BNE:   jump_o = (vj_i != vk_i);
         OP_BLT:   jump_o = ($signed(vj_i) <  $signed(vk_i));
         OP_BGE:   jump_o = ($signed(vj_i) >= $signed(vk_i));
         OP_BLTU:  jump_o = (vj_i <  vk_i);
         OP_BGEU:  jump_o = (vj_i >= vk_i);
         OP_ADDI:  value_o = vj_i + a_i;
         OP_SLTI:  value_o = b2w($signed(vj_i) < $signed(a_i));
         OP_SLTIU: value_o = b2w(vj_i < a_i);
         OP_XORI:  value_o = vj_i ^ a_i;
         OP_ORI:   value_o = vj_i | a_i;
         OP_ANDI:  value_o = vj_i & a_i;
         OP_SLLI:  value_o = vj_i << sh_imm;
         OP_SRLI:  value_o = vj_i >> sh_imm;
         OP_SRAI:  value_o = $signed(vj_i) >>> sh_imm;
         OP_ADD:   value_o = vj_i + vk_i;
         OP_SUB:   value_o = vj_i - vk_i;
         OP_SLL:   value_o = vj_i << sh_reg;
         OP_SLT:   value_o = b2w($signed(vj_i) < $signed(vk_i));
         OP_SLTU:  value_o = b2w(vj_i < vk_i);
         OP_XOR:   value_o = vj_i ^ vk_i;
         OP_SRL:   value_o = vj_i >> sh_reg;
         OP_SRA:   value_o = $signed(vj_i) >>> sh_reg;
         OP_OR:    value_o = vj_i | vk_i;
         OP_AND:   value_o = vj_i & vk_i;
         default:  ;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute unit: takes one issue per cycle from the RS and broadcasts on the ALU CDB lane.
// Ports: clk, rst (sync, active-high), rdy (0 = freeze), clr (flush), ALU_* issue in, CDB_ALU_* out.
// Latency 2 (E1 issue register, E2 CDB register); ALU_FAST_EN drops E1 for latency 1. No back-pressure.
module alu_exec_unit
   import alu_exec_unit_pkg::*;
#(
   parameter int OP_W  = ALU_OP_W,
   parameter int ROB_W = ALU_ROB_W,
   parameter int XLEN  = ALU_XLEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             clr,
   input  logic             ALU_S,
   input  logic [OP_W-1:0]  ALU_Op,
   input  logic [XLEN-1:0]  ALU_Vj,
   input  logic [XLEN-1:0]  ALU_Vk,
   input  logic [XLEN-1:0]  ALU_A,
   input  logic [XLEN-1:0]  ALU_pc,
   input  logic [ROB_W-1:0] ALU_Reorder,
   output logic             CDB_ALU_S,
   output logic [ROB_W-1:0] CDB_ALU_Reorder,
   output logic [XLEN-1:0]  CDB_ALU_Value,
   output logic             CDB_ALU_Jump,
   output logic [XLEN-1:0]  CDB_ALU_Target
);

   // Operands presented to the datapath this cycle.
   logic             ex_vld;
   logic [OP_W-1:0]  ex_op;
   logic [XLEN-1:0]  ex_vj, ex_vk, ex_a, ex_pc;
   logic [ROB_W-1:0] ex_tag;

   logic [XLEN-1:0]  core_value, core_target;
   logic             core_jump;

`ifdef ALU_FAST_EN
   assign ex_vld = ALU_S;
   assign ex_op  = ALU_Op;
   assign ex_vj  = ALU_Vj;
   assign ex_vk  = ALU_Vk;
   assign ex_a   = ALU_A;
   assign ex_pc  = ALU_pc;
   assign ex_tag = ALU_Reorder;
`else
   logic             e1_vld_q, e1_vld_d;
   logic [OP_W-1:0]  e1_op_q, e1_op_d;
   logic [XLEN-1:0]  e1_vj_q, e1_vj_d, e1_vk_q, e1_vk_d;
   logic [XLEN-1:0]  e1_a_q, e1_a_d, e1_pc_q, e1_pc_d;
   logic [ROB_W-1:0] e1_tag_q, e1_tag_d;

   always_comb begin
      e1_vld_d = ALU_S;
      e1_op_d  = ALU_Op;
      e1_vj_d  = ALU_Vj;
      e1_vk_d  = ALU_Vk;
      e1_a_d   = ALU_A;
      e1_pc_d  = ALU_pc;
      e1_tag_d = ALU_Reorder;
   end

   // Flush acts even while stalled, so clr is checked ahead of rdy.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         e1_vld_q <= 1'b0;
         e1_op_q  <= '0;
         e1_vj_q  <= '0;
         e1_vk_q  <= '0;
         e1_a_q   <= '0;
         e1_pc_q  <= '0;
         e1_tag_q <= '0;
      end else if (rdy) begin
         e1_vld_q <= e1_vld_d;
         e1_op_q  <= e1_op_d;
         e1_vj_q  <= e1_vj_d;
         e1_vk_q  <= e1_vk_d;
         e1_a_q   <= e1_a_d;
         e1_pc_q  <= e1_pc_d;
         e1_tag_q <= e1_tag_d;
      end
   end

   assign ex_vld = e1_vld_q;
   assign ex_op  = e1_op_q;
   assign ex_vj  = e1_vj_q;
   assign ex_vk  = e1_vk_q;
   assign ex_a   = e1_a_q;
   assign ex_pc  = e1_pc_q;
   assign ex_tag = e1_tag_q;
`endif

   alu_exec_core #(
      .OP_W (OP_W),
      .XLEN (XLEN)
   ) u_core (
      .op_i     (ex_op),
      .vj_i     (ex_vj),
      .vk_i     (ex_vk),
      .a_i      (ex_a),
      .pc_i     (ex_pc),
      .value_o  (core_value),
      .jump_o   (core_jump),
      .target_o (core_target)
   );

   logic             cdb_vld_q, cdb_vld_d;
   logic [ROB_W-1:0] cdb_tag_q, cdb_tag_d;
   logic [XLEN-1:0]  cdb_value_q, cdb_value_d;
   logic             cdb_jump_q, cdb_jump_d;
   logic [XLEN-1:0]  cdb_target_q, cdb_target_d;

   always_comb begin
      cdb_vld_d    = ex_vld;
      cdb_tag_d    = ex_tag;
      cdb_value_d  = core_value;
      // A bubble must never look like a redirect.
      cdb_jump_d   = ex_vld & core_jump;
      cdb_target_d = core_target;
   end

   // While rdy=0 the broadcast is held, so each result is seen in exactly one rdy=1 cycle.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cdb_vld_q    <= 1'b0;
         cdb_tag_q    <= '0;
         cdb_value_q  <= '0;
         cdb_jump_q   <= 1'b0;
         cdb_target_q <= '0;
      end else if (rdy) begin
         cdb_vld_q    <= cdb_vld_d;
         cdb_tag_q    <= cdb_tag_d;
         cdb_value_q  <= cdb_value_d;
         cdb_jump_q   <= cdb_jump_d;
         cdb_target_q <= cdb_target_d;
      end
   end

   assign CDB_ALU_S       = cdb_vld_q;
   assign CDB_ALU_Reorder = cdb_tag_q;
   assign CDB_ALU_Value   = cdb_value_q;
   assign CDB_ALU_Jump    = cdb_jump_q;
   assign CDB_ALU_Target  = cdb_target_q;

endmodule
